// File: rtl/dual_port_ram_pkg.sv
// dual_port_ram_pkg: shared FSM states, pattern mode codes and the expected-data function
package dual_port_ram_pkg;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

    localparam logic [1:0] MODE_INC  = 2'd0;
    localparam logic [1:0] MODE_INV  = 2'd1;
    localparam logic [1:0] MODE_WALK = 2'd2;
    localparam logic [1:0] MODE_AA55 = 2'd3;

    // Result is computed at 64 bits and masked to dw; callers truncate to their width.
    function automatic logic [63:0] exp_data(input logic [31:0] addr, input logic [1:0] mode, input int dw);
        logic [63:0] m;
        logic [63:0] r;
        m = (dw >= 64) ? '1 : (64'd1 << dw) - 64'd1;
        r = mode == MODE_INC  ? 64'(addr) + 64'd1 :
            mode == MODE_INV  ? ~64'(addr) :
            mode == MODE_WALK ? 64'd1 << (addr % 32'(dw)) :
            addr[0]           ? 64'h5A5A_5A5A_5A5A_5A5A : 64'hA5A5_A5A5_A5A5_A5A5;
        return r & m;
    endfunction

endpackage

// File: rtl/dual_port_ram_sdp_ram.sv
// sdp_ram: simple dual-port RAM, write-only port A, read-only port B with registered output
module sdp_ram #(
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic          clka,
    input  logic          ena,
    input  logic          wea,
    input  logic [AW-1:0] addra,
    input  logic [DW-1:0] dina,
    input  logic          clkb,
    input  logic          enb,
    input  logic [AW-1:0] addrb,
    output logic [DW-1:0] doutb
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clka)
        if (ena && wea) mem[addra] <= dina;

    always_ff @(posedge clkb)
        if (enb) doutb <= mem[addrb];

endmodule

// File: rtl/dual_port_ram_bist.sv
// dual_port_ram_bist: fill-then-verify self-test of an sdp_ram with selectable patterns,
// error count, first failing address and optional single-word corruption.
module dual_port_ram_bist
    import dual_port_ram_pkg::*;
#(
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic          inj_en,
    input  logic [AW-1:0] inj_addr,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW:0]   err_cnt,
    output logic [AW-1:0] first_err_addr
);

    state_t        state;
    logic [AW-1:0] addr;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] inj_addr_q;
    logic [1:0]    mode_q;
    logic          inj_q;
    logic          drain;
    logic          rd_vld;
    logic [DW-1:0] exp_w;
    logic [DW-1:0] rd_exp;
    logic [DW-1:0] dina;
    logic [DW-1:0] doutb;
    logic          wea;
    logic          enb;
    logic          mis;

    assign exp_w = DW'(exp_data(32'(addr), mode_q, DW));
    assign wea   = state == S_WRITE;
    assign enb   = state == S_READ && !drain;
    assign dina  = exp_w ^ DW'(inj_q && addr == inj_addr_q);
    assign mis   = rd_vld && doutb != rd_exp;

    sdp_ram #(.AW(AW), .DW(DW)) u_ram (
        .clka  (sys_clk),
        .ena   (wea),
        .wea   (wea),
        .addra (addr),
        .dina  (dina),
        .clkb  (sys_clk),
        .enb   (enb),
        .addrb (addr),
        .doutb (doutb)
    );

    // Expected data and address follow the read by one cycle to meet the registered doutb.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state          <= S_IDLE;
            addr           <= '0;
            rd_addr        <= '0;
            rd_exp         <= '0;
            rd_vld         <= 1'b0;
            drain          <= 1'b0;
            mode_q         <= MODE_INC;
            inj_q          <= 1'b0;
            inj_addr_q     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            done    <= 1'b0;
            rd_vld  <= enb;
            rd_addr <= addr;
            rd_exp  <= exp_w;
            if (mis) begin
                if (err_cnt == '0) first_err_addr <= rd_addr;
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end
            case (state)
                S_IDLE: if (start) begin
                    state          <= S_WRITE;
                    mode_q         <= mode;
                    inj_q          <= inj_en;
                    inj_addr_q     <= inj_addr;
                    err_cnt        <= '0;
                    first_err_addr <= '0;
                    pass           <= 1'b0;
                    busy           <= 1'b1;
                    addr           <= '0;
                end
                S_WRITE: begin
                    addr <= addr + 1'b1;
                    if (addr == '1) state <= S_READ;
                end
                S_READ: if (drain) begin
                    drain <= 1'b0;
                    state <= S_DONE;
                end else begin
                    addr  <= addr + 1'b1;
                    drain <= addr == '1;
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= err_cnt == '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dual_port_ram_bist.sv
// tb_dual_port_ram_bist: directed runs of the RAM self-test with hand-computed results
module tb_dual_port_ram_bist;
    import dual_port_ram_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          start;
    logic [1:0]    mode;
    logic          inj_en;
    logic [AW-1:0] inj_addr;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW:0]   err_cnt;
    logic [AW-1:0] first_err_addr;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] word5;

    always #5 sys_clk = ~sys_clk;

    dual_port_ram_bist #(.AW(AW), .DW(DW)) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .start          (start),
        .mode           (mode),
        .inj_en         (inj_en),
        .inj_addr       (inj_addr),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Starts a run and waits for done; poke >= 0 pulses start that many cycles into the run.
    task automatic run(input logic [1:0] m, input logic ie, input logic [AW-1:0] ia, input int poke, output int cyc);
        mode = m; inj_en = ie; inj_addr = ia; start = 1'b1; word5 = '0;
        @(posedge sys_clk); #1;
        start = 1'b0;
        check("busy_at_start", busy, 1);
        cyc = 0;
        while (!done && cyc < 200) begin
            start = (cyc == poke);
            @(posedge sys_clk); #1;
            cyc++;
            if (dut.rd_vld && dut.rd_addr == 4'd5) word5 = dut.doutb;
        end
        start = 1'b0;
        check("done_seen", done, 1);
    endtask

    initial begin
        int cyc;
        int n_done;
        int n_busy;
        int t_done [3];
        sys_rst = 1'b0; start = 1'b0; mode = '0; inj_en = 1'b0; inj_addr = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_first_err", first_err_addr, 0);
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;

        run(MODE_INC, 1'b0, 4'd0, -1, cyc);
        check("inc_latency", cyc, 34);
        check("inc_pass", pass, 1);
        check("inc_err_cnt", err_cnt, 0);
        check("inc_first_err", first_err_addr, 0);
        check("inc_busy_end", busy, 0);
        @(posedge sys_clk); #1;
        check("inc_done_pulse", done, 0);
        check("inc_pass_held", pass, 1);

        run(MODE_INV, 1'b1, 4'd5, -1, cyc);
        check("inv_pass", pass, 0);
        check("inv_err_cnt", err_cnt, 1);
        check("inv_first_err", first_err_addr, 5);
        check("inv_word5", word5, 8'hFB);

        run(MODE_WALK, 1'b1, 4'd15, -1, cyc);
        check("walk_err_cnt", err_cnt, 1);
        check("walk_first_err", first_err_addr, 15);
        check("walk_pass", pass, 0);

        run(MODE_AA55, 1'b1, 4'd0, -1, cyc);
        check("aa55_inj0_err_cnt", err_cnt, 1);
        check("aa55_inj0_first_err", first_err_addr, 0);

        force dut.doutb[7] = 1'b1;
        run(MODE_AA55, 1'b0, 4'd0, 10, cyc);
        release dut.doutb[7];
        check("stuck_latency", cyc, 34);
        check("stuck_err_cnt", err_cnt, 8);
        check("stuck_first_err", first_err_addr, 1);
        n_done = 0; n_busy = 0;
        repeat (40) begin
            @(posedge sys_clk); #1;
            if (done) n_done++;
            if (busy) n_busy++;
        end
        check("busy_start_ignored_done", n_done, 0);
        check("busy_start_ignored_busy", n_busy, 0);

        mode = MODE_INC; inj_en = 1'b0; start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        repeat (20) @(posedge sys_clk);
        #1;
        check("abort_busy_before", busy, 1);
        sys_rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_err_cnt", err_cnt, 0);
        check("abort_state", dut.state, S_IDLE);
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        n_done = 0;
        repeat (50) begin
            @(posedge sys_clk); #1;
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        run(MODE_INC, 1'b0, 4'd0, -1, cyc);
        check("after_abort_latency", cyc, 34);
        check("after_abort_pass", pass, 1);

        mode = MODE_WALK; inj_en = 1'b1; inj_addr = 4'd3; start = 1'b1;
        @(posedge sys_clk); #1;
        cyc = 0; n_done = 0;
        while (n_done < 3 && cyc < 200) begin
            @(posedge sys_clk); #1;
            cyc++;
            if (done) begin
                t_done[n_done] = cyc;
                check("b2b_err_cnt", err_cnt, 1);
                n_done++;
                if (n_done == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        check("b2b_count", n_done, 3);
        check("b2b_done0", t_done[0], 34);
        check("b2b_done1", t_done[1], 69);
        check("b2b_done2", t_done[2], 104);
        @(posedge sys_clk); #1;
        check("b2b_stopped", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
